// File: rtl/apb_pkg.sv
// Shared APB types and constants for the register-file completer and its scoreboard.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned IDX_W      = APB_ADDR_W - 2;
  localparam int unsigned CNT_W      = 3;

  localparam logic [APB_DATA_W-1:0] APB_ID_DEFAULT = 32'hABC0_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } apb_state_e;

  typedef enum logic {
    RESP_OKAY   = 1'b0,
    RESP_SLVERR = 1'b1
  } apb_resp_e;

  // Out-of-range words and writes to the read-only ID word both error.
  function automatic apb_resp_e decode_resp(input logic is_write,
                                            input logic is_id_word,
                                            input logic in_range);
    if (!in_range || (is_write && is_id_word)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester (master) and the register-file completer (slave).
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic [APB_ADDR_W-1:0] paddr;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_regfile_mem.sv
// DEPTH x 32 word store: synchronous write, combinational read, word 0 fixed to the ID value.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int unsigned           DEPTH    = 48,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = APB_ID_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0) && ({1'b0, waddr} < DEPTH_LIM)) mem_d[waddr] = wdata;
  end

  // NOTE: this array must come up cleared, so it is reset like any other flop;
  // that keeps it in registers rather than a RAM macro, which is fine at this size.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr == '0)                    rdata = ID_VALUE;
    else if ({1'b0, raddr} < DEPTH_LIM) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: setup/wait/done FSM with programmable wait states, serving a 32-bit register file.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned           WAIT_STATES = 1,
  parameter int unsigned           DEPTH       = 48,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  apb_slave_regfile_if.slave bus
);

  localparam logic [IDX_W:0]     DEPTH_LIM = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   WS_LOAD   = CNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic                  setup, access, enter_done;
  logic [IDX_W-1:0]      tgt_idx;
  logic                  tgt_wr, tgt_in_range, cur_in_range;
  logic                  mem_we;
  logic [APB_DATA_W-1:0] mem_rdata;
  apb_resp_e             resp;
  logic                  unused_addr_lsbs;

  assign setup            = bus.psel && !bus.penable;
  assign access           = bus.psel && bus.penable;
  assign unused_addr_lsbs = ^bus.paddr[1:0];
  assign cur_in_range     = {1'b0, idx_q} < DEPTH_LIM;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    enter_done = 1'b0;
    tgt_idx    = idx_q;
    tgt_wr     = wr_q;

    // A setup phase restarts the transfer from any state, including mid-transfer.
    if (setup) begin
      tgt_idx = bus.paddr[APB_ADDR_W-1:2];
      tgt_wr  = bus.pwrite;
      idx_d   = tgt_idx;
      wr_d    = tgt_wr;
      wdata_d = bus.pwdata;
      if (WAIT_STATES == 0) begin
        cnt_d      = '0;
        state_d    = ST_DONE;
        enter_done = 1'b1;
      end else begin
        cnt_d   = WS_LOAD;
        state_d = ST_WAIT;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (!bus.psel) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            cnt_d      = '0;
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tgt_in_range = {1'b0, tgt_idx} < DEPTH_LIM;
  assign resp         = decode_resp(tgt_wr, tgt_idx == '0, tgt_in_range);

  always_comb begin
    pready_d  = enter_done;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (enter_done) begin
      pslverr_d = (resp == RESP_SLVERR);
      if (!tgt_wr && tgt_in_range) prdata_d = mem_rdata;
    end
  end

  // The write lands only when the completing access cycle is actually seen.
  assign mem_we = (state_q == ST_DONE) && access && wr_q && cur_in_range && (idx_q != '0);

  apb_regfile_mem #(
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (tgt_idx),
    .rdata (mem_rdata)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: four instances (0, 1, 3, 7 wait states) behind one APB driver.
module tb_apb_slave_regfile;

  typedef struct {
    int          sel;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        chk_rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          sel = 1;
  logic        psel_drv, penable_drv, pwrite_drv;
  logic [7:0]  paddr_drv;
  logic [31:0] pwdata_drv;
  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  apb_slave_regfile_if if0 ();
  apb_slave_regfile_if if1 ();
  apb_slave_regfile_if if3 ();
  apb_slave_regfile_if if7 ();

  assign if0.psel = psel_drv && (sel == 0);
  assign if1.psel = psel_drv && (sel == 1);
  assign if3.psel = psel_drv && (sel == 3);
  assign if7.psel = psel_drv && (sel == 7);
  assign {if0.penable, if1.penable, if3.penable, if7.penable} = {4{penable_drv}};
  assign {if0.pwrite, if1.pwrite, if3.pwrite, if7.pwrite}     = {4{pwrite_drv}};
  assign {if0.paddr, if1.paddr, if3.paddr, if7.paddr}         = {4{paddr_drv}};
  assign {if0.pwdata, if1.pwdata, if3.pwdata, if7.pwdata}     = {4{pwdata_drv}};

  apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  apb_slave_regfile #(.WAIT_STATES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  apb_slave_regfile #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));
  apb_slave_regfile #(.WAIT_STATES(7)) u_dut7 (.clk(clk), .reset(reset), .bus(if7));

  always_comb begin
    pready_m  = if1.pready;
    pslverr_m = if1.pslverr;
    prdata_m  = if1.prdata;
    case (sel)
      0: begin pready_m = if0.pready; pslverr_m = if0.pslverr; prdata_m = if0.prdata; end
      3: begin pready_m = if3.pready; pslverr_m = if3.pslverr; prdata_m = if3.prdata; end
      7: begin pready_m = if7.pready; pslverr_m = if7.pslverr; prdata_m = if7.prdata; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s, input logic wr, input logic [7:0] a,
                              input logic [31:0] d, input logic [31:0] rd,
                              input logic err, input string name);
    vec_t v;
    v.sel = s; v.wr = wr; v.addr = a; v.wdata = d; v.rdata = rd; v.err = err; v.name = name;
    return v;
  endfunction

  // Called at a drive point (1 time unit after a rising edge); leaves the bus idle
  // at the next drive point after the completing access cycle.
  task automatic xfer(input int s, input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    exp_t e;
    int   k;
    bit   done;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = s + 1; e.chk_rdata = !wr;
    sb_q.push_back(e);
    sel = s; psel_drv = 1'b1; penable_drv = 1'b0;
    paddr_drv = a; pwrite_drv = wr; pwdata_drv = d;
    @(negedge clk);
    check({tag, " setup pready"}, 32'(pready_m), 32'd0);
    @(posedge clk); #1;
    penable_drv = 1'b1;
    paddr_drv = a ^ 8'h40; pwrite_drv = ~wr; pwdata_drv = ~d;
    k = 1; done = 0;
    while (!done && k <= 20) begin
      @(negedge clk);
      if (pready_m) begin
        e = sb_q.pop_front();
        check({tag, " latency"}, 32'(k), 32'(e.lat));
        check({tag, " pslverr"}, 32'(pslverr_m), 32'(e.err));
        if (e.chk_rdata) check({tag, " prdata"}, prdata_m, e.rdata);
        done = 1;
      end else begin
        k++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      e = sb_q.pop_front();
      checks++; errors++;
      $display("FAIL %s timeout: no pready, expected after %0d cycles", tag, e.lat);
    end
    psel_drv = 1'b0; penable_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    reset = 1'b0; psel_drv = 1'b0; penable_drv = 1'b0;
    pwrite_drv = 1'b0; paddr_drv = '0; pwdata_drv = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset pready",  32'({if0.pready, if1.pready, if3.pready, if7.pready}), 32'd0);
    check("reset pslverr", 32'({if0.pslverr, if1.pslverr, if3.pslverr, if7.pslverr}), 32'd0);
    check("reset prdata",  if0.prdata | if1.prdata | if3.prdata | if7.prdata, 32'd0);
    @(posedge clk); #1;

    vecs.push_back(mk(1, 1'b0, 8'h14, 32'h0,         32'h0,         1'b0, "rd w5 after reset"));
    vecs.push_back(mk(1, 1'b1, 8'h10, 32'h1234_5678, 32'h0,         1'b0, "wr w4"));
    vecs.push_back(mk(1, 1'b0, 8'h10, 32'h0,         32'h1234_5678, 1'b0, "rd w4 b2b"));
    vecs.push_back(mk(1, 1'b0, 8'h00, 32'h0,         32'hABC0_0100, 1'b0, "rd id"));
    vecs.push_back(mk(1, 1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0,         1'b1, "wr id"));
    vecs.push_back(mk(1, 1'b0, 8'h00, 32'h0,         32'hABC0_0100, 1'b0, "rd id again"));
    vecs.push_back(mk(1, 1'b1, 8'hC0, 32'hDEAD_BEEF, 32'h0,         1'b1, "wr w48"));
    vecs.push_back(mk(1, 1'b0, 8'hFC, 32'h0,         32'h0,         1'b1, "rd w63"));
    vecs.push_back(mk(1, 1'b0, 8'hBC, 32'h0,         32'h0,         1'b0, "rd w47 empty"));
    vecs.push_back(mk(1, 1'b1, 8'hBF, 32'hA5A5_5A5A, 32'h0,         1'b0, "wr w47 lsbs"));
    vecs.push_back(mk(1, 1'b0, 8'hBC, 32'h0,         32'hA5A5_5A5A, 1'b0, "rd w47"));
    vecs.push_back(mk(1, 1'b1, 8'h13, 32'hCAFE_F00D, 32'h0,         1'b0, "wr w4 via 13"));
    vecs.push_back(mk(1, 1'b0, 8'h11, 32'h0,         32'hCAFE_F00D, 1'b0, "rd w4 via 11"));
    vecs.push_back(mk(0, 1'b0, 8'h00, 32'h0,         32'hABC0_0100, 1'b0, "ws0 rd id"));
    vecs.push_back(mk(0, 1'b1, 8'h08, 32'h0BAD_F00D, 32'h0,         1'b0, "ws0 wr w2"));
    vecs.push_back(mk(0, 1'b0, 8'h08, 32'h0,         32'h0BAD_F00D, 1'b0, "ws0 rd w2"));
    vecs.push_back(mk(3, 1'b0, 8'h00, 32'h0,         32'hABC0_0100, 1'b0, "ws3 rd id"));
    vecs.push_back(mk(7, 1'b0, 8'h00, 32'h0,         32'hABC0_0100, 1'b0, "ws7 rd id"));

    foreach (vecs[i])
      xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].name);

    // psel dropped in A1 of a 3-wait-state write: no completion, no write.
    sel = 3; psel_drv = 1'b1; penable_drv = 1'b0;
    paddr_drv = 8'h20; pwrite_drv = 1'b1; pwdata_drv = 32'h55AA_55AA;
    @(posedge clk); #1;
    psel_drv = 1'b0; penable_drv = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready_m) hits++;
    end
    check("abort A1 pready count", 32'(hits), 32'd0);
    @(posedge clk); #1;
    penable_drv = 1'b0;
    xfer(3, 1'b0, 8'h20, 32'h0, 32'h0, 1'b0, "rd after A1 abort");

    // psel dropped in the completing cycle of a write: pready shows, write is lost.
    sel = 1; psel_drv = 1'b1; penable_drv = 1'b0;
    paddr_drv = 8'h24; pwrite_drv = 1'b1; pwdata_drv = 32'h7777_8888;
    @(posedge clk); #1;
    penable_drv = 1'b1;
    @(posedge clk); #1;
    psel_drv = 1'b0; penable_drv = 1'b0;
    @(negedge clk);
    check("done abort pready", 32'(pready_m), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done abort pready clear", 32'(pready_m), 32'd0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h24, 32'h0, 32'h0, 1'b0, "rd after done abort");

    // Reset in the middle of a 7-wait-state write.
    xfer(7, 1'b1, 8'h30, 32'h1111_2222, 32'h0,         1'b0, "ws7 wr w12");
    xfer(7, 1'b0, 8'h30, 32'h0,         32'h1111_2222, 1'b0, "ws7 rd w12");
    sel = 7; psel_drv = 1'b1; penable_drv = 1'b0;
    paddr_drv = 8'h30; pwrite_drv = 1'b1; pwdata_drv = 32'h3333_4444;
    @(posedge clk); #1;
    penable_drv = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid reset pready",  32'(pready_m),  32'd0);
    check("mid reset pslverr", 32'(pslverr_m), 32'd0);
    check("mid reset prdata",  prdata_m,       32'd0);
    @(posedge clk); #1;
    reset = 1'b1; psel_drv = 1'b0; penable_drv = 1'b0;
    xfer(7, 1'b0, 8'h30, 32'h0, 32'h0,         1'b0, "ws7 rd w12 after reset");
    xfer(1, 1'b0, 8'h10, 32'h0, 32'h0,         1'b0, "ws1 rd w4 after reset");
    xfer(0, 1'b0, 8'h00, 32'h0, 32'hABC0_0100, 1'b0, "ws0 rd id after reset");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) that terminates transfers issued by the testbench's APB driver and serves them from an internal 32-bit register file. Inserts a parameterised number of wait states via `pready`, flags out-of-range accesses on `pslverr`, and exposes a read-only ID word. It is the DUT-side counterpart that the APB driver, monitor and scoreboard run against.

## Interface
- `WAIT_STATES`, default 1: access-phase cycles with `pready`=0 before completion, range 0–7.
- `DEPTH`, default 48: implemented 32-bit words; word index = `paddr[7:2]`, range 1–64.
- `ID_VALUE`, default 32'hABC0_0100: constant returned from word 0.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `psel` in 1: slave select.
- `penable` in 1: access-phase strobe.
- `paddr` in 8: byte address; bits [1:0] ignored.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in 32: write data.
- `pready` out 1: transfer completion, registered.
- `prdata` out 32: read data, registered, valid only while `pready`=1 on a read.
- `pslverr` out 1: error response, registered, valid only while `pready`=1.

## Operation
- Reset (`reset`=0 at a rising edge): `pready`=0, `prdata`=0, `pslverr`=0, all words 1..DEPTH-1 = 0, FSM to IDLE, wait counter = 0. Takes priority over everything, including mid-transfer.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: at an edge sampling `psel`=1, `penable`=0 (setup phase), latch `paddr[7:2]`, `pwrite`, `pwdata`. If WAIT_STATES=0 go to DONE, otherwise load counter = WAIT_STATES and go to WAIT.
  - WAIT: each edge with `psel`=1, `penable`=1 decrements the counter. Go to DONE at the edge where the counter is 1.
  - DONE: `pready`=1 for exactly one cycle. Then return to IDLE.
- Response computed on entry to DONE (same edge `pready` rises):
  - Word index ≥ DEPTH: `pslverr`=1. Read returns `prdata`=0. Write is discarded.
  - Word 0 read: `prdata`=ID_VALUE.
  - Word 0 write: discarded, `pslverr`=1.
  - Other read: `prdata`=mem[index].
  - Other write: commits `pwdata` to mem[index] at the edge leaving DONE, only if `psel`=1, `penable`=1 are sampled there.
- Abort: `psel`=0 sampled in WAIT or DONE returns the FSM to IDLE. No write occurs. `pready`, `pslverr` and `prdata` clear next cycle.
- Setup seen in WAIT/DONE (`psel`=1, `penable`=0) is a protocol violation. Treat it as a new setup: relatch and restart the counter.
- Outside DONE: `pready`=0, `pslverr`=0, `prdata`=0.

## Timing
- Setup cycle S, access cycles A1..An: `pready` is high in cycle A(WAIT_STATES+1). Total transfer = WAIT_STATES+2 cycles.
- Back-to-back: a new setup phase in the cycle right after DONE is accepted. No idle cycle is required.
- Read-after-write to the same word in consecutive transfers returns the new data.
- Address, `pwrite` and `pwdata` are taken from the setup-cycle sample. Later changes during the access phase are ignored.

## Structure
- Package `apb_pkg`:
  - FSM state enum (IDLE, WAIT, DONE).
  - `APB_ADDR_W`=8, `APB_DATA_W`=32.
  - Default ID constant.
  - Response-code constants shared with the scoreboard.
- Sub-module `apb_regfile_mem` holds the storage:
  - DEPTH×32 array with synchronous write port and combinational read port.
  - Synchronous active-low clear.
  - Word 0 hard-wired to ID_VALUE.
- Top level holds the FSM, wait counter, address decode and response registers.

## Test plan
- Reset then read word 5 with WAIT_STATES=1: `pready` high in A2, `prdata`=0, `pslverr`=0.
- Write 32'h1234_5678 to paddr 8'h10, then read 8'h10 back-to-back: readback = 32'h1234_5678. Each transfer is 3 cycles.
- Read paddr 8'h00: `prdata`=32'hABC0_0100. Write 8'h00 with 32'hFFFF_FFFF: `pslverr`=1, and a following read still returns the ID.
- DEPTH=48, write 8'hC0 (word 48) and read 8'hFC: `pslverr`=1 on both, `prdata`=0, no array change.
- Drop `psel` in A1 of a write to 8'h20 with WAIT_STATES=3: no `pready`, a later read of 8'h20 returns 0.
- Assert `reset`=0 during WAIT of a write: all outputs 0 next cycle, FSM in IDLE, target word unchanged. Rerun with WAIT_STATES=0 and 7 for the latency check.
